// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: peripheral slot offsets,
// status bit layout and the capture FSM state type.
package uart_rx_fifo_pkg;

  localparam logic [3:0] SLOT_DATA   = 4'h4;
  localparam logic [3:0] SLOT_STATUS = 4'h5;
  localparam logic [3:0] SLOT_CFG    = 4'hB;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_IRQ_BIT   = 2;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_WAIT = 1'b1
  } cap_state_t;

  // Builds the status slot word seen by the CPU read mux
  function automatic logic [7:0] pack_status(input logic [3:0] cnt,
                                             input logic       emp,
                                             input logic       ful,
                                             input logic       irq);
    logic [7:0] word;
    word                                = 8'h00;
    word[ST_EMPTY_BIT]                  = emp;
    word[ST_FULL_BIT]                   = ful;
    word[ST_IRQ_BIT]                    = irq;
    word[ST_COUNT_LSB+3:ST_COUNT_LSB]   = cnt;
    return word;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// First-word-fall-through byte FIFO with an explicitly tracked fill count.
// Push into a full FIFO and pop from an empty one are ignored; flush wins over both.
module byte_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          empty,
  output logic          full
);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          empty_r;
  logic          full_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualified push/pop and next fill count
  always_comb begin
    push_ok_s = push && !full_r && !flush;
    pop_ok_s  = pop && !empty_r && !flush;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        else           wr_ptr_r <= wr_ptr_r;
        if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
        else           rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {CW{1'b0}});
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data   = empty_r ? 8'h00 : mem_r[rd_ptr_r];
  assign count     = count_r;
  assign count_nxt = count_nxt_s;
  assign empty     = empty_r;
  assign full      = full_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one byte per uart_rx valid assertion into byte_fifo
// and raises a level irq at a fill threshold. UART_RX_FIFO_THRESH_EN adds a programmable threshold.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int THRESHOLD = 1,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef UART_RX_FIFO_THRESH_EN
  input  logic          set_thresh,
  input  logic [CW-1:0] thresh_in,
`endif
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ack,
  input  logic          rd_pop,
  output logic [7:0]    rd_data,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          irq
);

  cap_state_t    state_r;
  cap_state_t    state_nxt_s;
  logic          push_s;
  logic          in_ack_r;
  logic          irq_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] thresh_nxt_s;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (rd_pop),
    .flush     (flush),
    .wr_data   (in_data),
    .rd_data   (rd_data),
    .count     (count),
    .count_nxt (count_nxt_s),
    .empty     (empty),
    .full      (full)
  );

  // Capture state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= CAP_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Capture next state; WAIT holds off until uart_rx drops valid
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    if (flush) begin
      state_nxt_s = in_valid ? CAP_WAIT : CAP_IDLE;
    end else begin
      case (state_r)
        CAP_IDLE: begin
          if (in_valid && !full) begin
            push_s      = 1'b1;
            state_nxt_s = CAP_WAIT;
          end else begin
            state_nxt_s = CAP_IDLE;
          end
        end
        CAP_WAIT: begin
          if (!in_valid) state_nxt_s = CAP_IDLE;
          else           state_nxt_s = CAP_WAIT;
        end
        default: state_nxt_s = CAP_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic [CW-1:0] thresh_r;

  function automatic logic [CW-1:0] clamp_thresh(input logic [CW-1:0] val);
    if (val == {CW{1'b0}})   return CW'(1);
    else if (val > CW'(DEPTH)) return CW'(DEPTH);
    else                     return val;
  endfunction

  // Next threshold value from a software load
  always_comb begin
    if (set_thresh) thresh_nxt_s = clamp_thresh(thresh_in);
    else            thresh_nxt_s = thresh_r;
  end

  // Programmable threshold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) thresh_r <= CW'(THRESHOLD);
    else     thresh_r <= thresh_nxt_s;
  end
`else
  assign thresh_nxt_s = CW'(THRESHOLD);
`endif

  // Handshake pulse and irq, both tracking the next-state fill count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ack_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      in_ack_r <= push_s;
      irq_r    <= (count_nxt_s >= thresh_nxt_s);
    end
  end

  assign in_ack = in_ack_r;
  assign irq    = irq_r;

endmodule
